// File: rtl/hazard_ctrl.sv
// hazard_ctrl: E-stage forwarding, load-use/branch hazards and data-memory wait control
module hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             ResultSrcE0,
    input  logic             armE,
    input  logic             RVPCSrcE,
    input  logic             BranchTakenE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCycles
);
    localparam int WC_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, MEMWAIT, ERROR} state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic              lw_stall, br, mem_hold;

    function automatic logic [1:0] fwd(input logic [4:0] rs, input logic [4:0] rd_m,
                                       input logic [4:0] rd_w, input logic we_m,
                                       input logic we_w, input logic arm);
        if (we_m && rd_m == rs && (arm || rs != 5'd0)) return 2'b10;
        if (we_w && rd_w == rs && (arm || rs != 5'd0)) return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        if (state_q == RUN && MemReqM && !MemReadyM) begin
            state_d    = MEMWAIT;
            wait_cnt_d = WC_W'(1);
        end else if (state_q == MEMWAIT) begin
            if (MemReadyM) begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end else if (wait_cnt_q == WC_W'(TIMEOUT)) begin
                state_d = ERROR;
            end else begin
                wait_cnt_d = wait_cnt_q + WC_W'(1);
            end
        end
        mem_err_d = mem_err_q | (state_d == ERROR);
        lw_stall  = ResultSrcE0 && RegWriteE && (RdE == Rs1D || RdE == Rs2D) && (armE || RdE != 5'd0);
        br        = RVPCSrcE | BranchTakenE;
        // A memory hold freezes everything, so a taken branch waits in E until release
        mem_hold  = rst && ((state_q == RUN && MemReqM && !MemReadyM) || state_q != RUN);
        StallF    = mem_hold || (rst && !br && lw_stall);
        StallD    = StallF;
        StallE    = mem_hold;
        StallM    = mem_hold;
        FlushD    = rst && !mem_hold && br;
        FlushE    = rst && !mem_hold && (br || lw_stall);
        ForwardAE = rst ? fwd(Rs1E, RdM, RdW, RegWriteM, RegWriteW, armE) : 2'b00;
        ForwardBE = rst ? fwd(Rs2E, RdM, RdW, RegWriteM, RegWriteW, armE) : 2'b00;
        stall_cycles_d = stall_cycles_q + CNT_W'(StallF && !(&stall_cycles_q));
        MemErr      = mem_err_q;
        StallCycles = stall_cycles_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= RUN;
            wait_cnt_q     <= '0;
            mem_err_q      <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_err_q      <= mem_err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checking of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;
    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic RegWriteE, RegWriteM, RegWriteW, ResultSrcE0, armE, RVPCSrcE, BranchTakenE, MemReqM, MemReadyM;
    logic [1:0] ForwardAE, ForwardBE;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, MemErr;
    logic [CW-1:0] StallCycles;

    int total = 0;
    int bad = 0;
    bit m_wait, m_err;
    int m_n, m_cnt;

    hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .armE(armE), .RVPCSrcE(RVPCSrcE), .BranchTakenE(BranchTakenE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .MemErr(MemErr), .StallCycles(StallCycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", n, a, e, $time);
        end
    endtask

    function automatic int fwd_model(input logic [4:0] rs);
        if (RegWriteM && RdM == rs && (armE || rs != 0)) return 2;
        if (RegWriteW && RdW == rs && (armE || rs != 0)) return 1;
        return 0;
    endfunction

    // Model: outputs from the current inputs and wait history, then advance the history
    always @(negedge clk) begin
        bit hold, brm, lw, sf, fd, fe;
        if (!rst) begin
            m_wait = 0; m_err = 0; m_n = 0; m_cnt = 0;
            chk("rst_ctl", int'({StallF, StallD, StallE, StallM, FlushD, FlushE}), 0);
            chk("rst_fwd", int'({ForwardAE, ForwardBE}), 0);
            chk("rst_err", int'(MemErr), 0);
            chk("rst_cnt", int'(StallCycles), 0);
        end else begin
            hold = m_err || m_wait || (MemReqM && !MemReadyM);
            brm  = RVPCSrcE || BranchTakenE;
            lw   = ResultSrcE0 && RegWriteE && (RdE == Rs1D || RdE == Rs2D) && (armE || RdE != 0);
            sf   = hold || (!brm && lw);
            fd   = !hold && brm;
            fe   = !hold && (brm || lw);
            chk("ctl", int'({StallF, StallD, StallE, StallM, FlushD, FlushE}), int'({sf, sf, hold, hold, fd, fe}));
            chk("fwdA", int'(ForwardAE), fwd_model(Rs1E));
            chk("fwdB", int'(ForwardBE), fwd_model(Rs2E));
            chk("memerr", int'(MemErr), int'(m_err));
            chk("cnt", int'(StallCycles), m_cnt);
            if (!m_err) begin
                if (m_wait) begin
                    if (MemReadyM) m_wait = 0;
                    else if (m_n == TO) m_err = 1;
                    else m_n++;
                end else if (MemReqM && !MemReadyM) begin
                    m_wait = 1; m_n = 1;
                end
            end
            if (sf && m_cnt < CMAX) m_cnt++;
        end
    end

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic sm();
        @(negedge clk);
    endtask

    task automatic clear();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {RegWriteE, RegWriteM, RegWriteW, ResultSrcE0, armE, RVPCSrcE, BranchTakenE, MemReqM, MemReadyM} = '0;
    endtask

    task automatic rand_in();
        Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
        Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
        RdE = 5'($urandom_range(0, 3)); RdM = 5'($urandom_range(0, 3)); RdW = 5'($urandom_range(0, 3));
        RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
        ResultSrcE0 = 1'($urandom); armE = 1'($urandom);
        RVPCSrcE = ($urandom_range(0, 5) == 0); BranchTakenE = ($urandom_range(0, 5) == 0);
        MemReqM = ($urandom_range(0, 2) == 0); MemReadyM = ($urandom_range(0, 4) != 0);
        rst = ($urandom_range(0, 40) != 0);
    endtask

    initial begin
        rst = 1'b0;
        clear();
        nx(); nx();
        sm();
        chk("reset_stallF", int'(StallF), 0);
        chk("reset_cnt", int'(StallCycles), 0);
        nx(); rst = 1'b1;
        // Forwarding priority and r0 handling
        nx(); RegWriteM = 1; RdM = 5; Rs1E = 5; RegWriteW = 1; RdW = 5;
        sm(); chk("fwd_m_over_w", int'(ForwardAE), 2);
        nx(); RdM = 0; Rs1E = 0; RegWriteW = 0; armE = 0;
        sm(); chk("fwd_r0_rv", int'(ForwardAE), 0);
        nx(); armE = 1;
        sm(); chk("fwd_r0_arm", int'(ForwardAE), 2);
        nx(); clear(); RegWriteW = 1; RdW = 3; Rs2E = 3;
        sm(); chk("fwd_w", int'(ForwardBE), 1);
        // Load-use stall, then branch overriding it
        nx(); clear(); ResultSrcE0 = 1; RegWriteE = 1; RdE = 7; Rs2D = 7;
        sm(); chk("lw_stallF", int'(StallF), 1); chk("lw_flushE", int'(FlushE), 1); chk("lw_stallE", int'(StallE), 0);
        nx(); clear();
        sm(); chk("lw_once", int'(StallF), 0);
        nx(); ResultSrcE0 = 1; RegWriteE = 1; RdE = 7; Rs2D = 7; RVPCSrcE = 1;
        sm(); chk("br_flushD", int'(FlushD), 1); chk("br_stallF", int'(StallF), 0);
        // Memory wait with a held branch
        nx(); clear(); rst = 0;
        nx(); rst = 1; MemReqM = 1; RVPCSrcE = 1;
        sm(); chk("mw_stallM", int'(StallM), 1); chk("mw_noflush", int'(FlushD), 0);
        nx(); sm(); chk("mw_stallF1", int'(StallF), 1);
        nx(); MemReadyM = 1;
        sm(); chk("mw_stallF2", int'(StallF), 1);
        nx(); MemReqM = 0; MemReadyM = 0;
        sm(); chk("mw_release", int'(StallF), 0); chk("mw_br_flushD", int'(FlushD), 1);
        chk("mw_cnt", int'(StallCycles), 3);
        // Timeout into ERROR
        nx(); clear(); MemReqM = 1;
        repeat (4) nx();
        sm(); chk("to_not_yet", int'(MemErr), 0);
        nx(); MemReqM = 0; MemReadyM = 1;
        sm(); chk("to_err", int'(MemErr), 1); chk("to_stallM", int'(StallM), 1);
        repeat (3) nx();
        sm(); chk("to_sticky", int'(StallF), 1);
        nx(); #2 rst = 0;
        #1 chk("areset_ctl", int'({StallF, StallM, FlushE}), 0); chk("areset_err", int'(MemErr), 0);
        nx(); rst = 1; clear();
        sm(); chk("post_err_run", int'(StallF), 0);
        // Reset in the middle of a wait
        nx(); MemReqM = 1;
        nx(); sm(); chk("mid_wait", int'(StallF), 1);
        nx(); #2 rst = 0;
        #1 chk("mid_rst_stallF", int'(StallF), 0); chk("mid_rst_stallM", int'(StallM), 0);
        nx(); rst = 1; MemReqM = 0;
        sm(); chk("mid_rst_after", int'(StallF), 0); chk("mid_rst_noerr", int'(MemErr), 0);
        // Counter saturation
        nx(); ResultSrcE0 = 1; RegWriteE = 1; RdE = 7; Rs1D = 7;
        repeat (20) nx();
        sm(); chk("sat15", int'(StallCycles), 15);
        repeat (3) nx();
        sm(); chk("sat_hold", int'(StallCycles), 15);
        repeat (3000) begin
            nx();
            rand_in();
        end
        nx(); clear(); rst = 1;
        nx();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
